memdatos_ctrl: RTL and testbench
================================

# memdatos_ctrl

Word-addressed data memory with a wait-state controller, sitting directly downstream of the single-cycle MIPS datapath. It takes the ALU result as address and register operand 2 as write data, performs loads and stores over a fixed, parameterised number of wait cycles, and returns `datard` to the datapath's MemaReg mux. It raises `busy` so the PC and register-file write can be stalled until the access completes.

## Interface
- `DEPTH_LOG2`, default 8: memory holds 2^DEPTH_LOG2 32-bit words.
- `LATENCY`, default 2: wait cycles per access; legal range 1..15.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `LeerMem`  in  1  load request, level, from control path.
- `EscrMem`  in  1  store request, level, from control path.
- `addr`  in  32  word address, driven by ALU result.
- `datawr`  in  32  store data, driven by register-file read port 2.
- `datard`  out  32  load data to the MemaReg mux; holds its last load value.
- `busy`  out  1  stall request to the PC and the register-file write enable.
- `valid`  out  1  one-cycle pulse when a load completes.
- `err`  out  1  one-cycle pulse on an illegal request or an out-of-range access.

## Operation
- The controller has three states: IDLE, WAIT and DONE. A 4-bit down-counter `cnt` times the wait cycles.
- **IDLE, exactly one of `LeerMem`/`EscrMem` high:**
  - Latch `addr`, `datawr` and the operation.
  - Load `cnt = LATENCY-1` and move to WAIT.
  - `busy` is high combinationally during this cycle.
- **IDLE, both requests high:**
  - Illegal request: no access is made.
  - `err` = 1 for the cycle (combinational).
  - Stay in IDLE with `busy` = 0.
- **IDLE, no request:** `busy` = 0 and the state is held.
- **WAIT:**
  - `busy` = 1.
  - If `cnt` = 0, perform the access at this edge and move to DONE; otherwise decrement `cnt`.
  - Request inputs are ignored; the datapath holds them because it is stalled.
- **Access at the WAIT→DONE edge:**
  - Store: `mem[addr_l[DEPTH_LOG2-1:0]] <= datawr_l`.
  - Load: `datard <= mem[...]`.
- **Out of range:** if `addr_l[31:DEPTH_LOG2]` is nonzero, a store is dropped and a load returns 0. `err` = 1 in the DONE cycle.
- **DONE:**
  - `busy` = 0.
  - `valid` = 1 for loads only.
  - Always move to IDLE at the next edge.
  - Requests in DONE are ignored. They still belong to the completing instruction; the PC advances at the end of DONE.
- `datard` changes only on a load completion or on reset.
- **Reset values:** state = IDLE, `cnt` = 0, `datard` = 0, `valid` = 0, `err` = 0, `busy` = 0. Memory contents are not reset.
- **Reset mid-access:** the pending operation is cancelled and any store in flight is not written.

## Timing
- Define cycle 0 as the IDLE cycle in which the request is seen.
- `busy` is high in cycles 0..LATENCY, i.e. LATENCY+1 cycles.
- WAIT occupies cycles 1..LATENCY.
- DONE is cycle LATENCY+1: `datard` is valid there and `valid` pulses.
- The earliest next request is accepted in cycle LATENCY+2 (IDLE).
- Each access therefore costs LATENCY+2 cycles, request to next request.
- `busy` and `err` in IDLE are combinational from `LeerMem`/`EscrMem`. All other outputs are registered or decoded from state only.
- Reset assertion takes effect immediately, with no clock required. Deassertion is synchronised externally.

## Test plan
All scenarios use DEPTH_LOG2 = 8 and LATENCY = 2.

1. **Reset:** hold `rst` = 0, then release → `datard` = 0, `busy` = `valid` = `err` = 0, state IDLE.
2. **Store then load:** store `addr` = 0x10, `datawr` = 0xDEADBEEF, then load 0x10 → store shows `busy` high in cycles 0–2, `valid` never pulses; load returns `datard` = 0xDEADBEEF in cycle 3 with `valid` = 1; next request accepted in cycle 4.
3. **Illegal request:** `LeerMem` = `EscrMem` = 1 in IDLE → `err` = 1 that cycle, `busy` = 0, no state change, memory unchanged.
4. **Out-of-range store:** store `addr` = 0x100, `datawr` = 0x55, then load `addr` = 0x00 → `err` = 1 in DONE of the store; load of 0x00 returns its prior contents (0x55 was not written); a load of 0x100 returns 0 with `err` = 1.
5. **Requests held through DONE:** keep `LeerMem` high continuously → exactly one access per 4 cycles; the DONE-cycle request does not restart an access.
6. **Reset during WAIT of a store:** store 0x20 = 0x1234; assert `rst` in cycle 1; release; load 0x20 → the original contents are returned, not 0x1234; `busy` drops immediately when reset asserts.

Source files
------------

// File: rtl/memdatos_if.sv
// Datapath-to-data-memory bus: load/store requests, address and store data in;
// load data, stall and status pulses out.
interface memdatos_if;
    logic        LeerMem;
    logic        EscrMem;
    logic [31:0] addr;
    logic [31:0] datawr;
    logic [31:0] datard;
    logic        busy;
    logic        valid;
    logic        err;

    modport master (
        output LeerMem, EscrMem, addr, datawr,
        input  datard, busy, valid, err
    );

    modport slave (
        input  LeerMem, EscrMem, addr, datawr,
        output datard, busy, valid, err
    );
endinterface

// File: rtl/memdatos_ctrl.sv
// Word-addressed data memory behind an IDLE/WAIT/DONE wait-state controller.
// Each access costs LATENCY+2 cycles; busy stalls the PC and register-file write.
module memdatos_ctrl #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic      clk,
    input  logic      rst,
    memdatos_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        load_q, load_d;
    logic [31:0] datard_q, datard_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] mem [0:(1 << DEPTH_LOG2) - 1];

    logic one_req, both_req, oor, access;
    logic busy_c, valid_c, err_c;

    assign one_req  = bus.LeerMem ^ bus.EscrMem;
    assign both_req = bus.LeerMem & bus.EscrMem;
    assign oor      = |addr_q[31:DEPTH_LOG2];
    assign access   = (state_q == WAIT) && (cnt_q == 4'd0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load_d   = load_q;
        datard_d = datard_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        busy_c   = 1'b0;
        valid_c  = 1'b0;
        err_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (both_req) begin
                    err_c = 1'b1;
                end else if (one_req) begin
                    busy_c  = 1'b1;
                    addr_d  = bus.addr;
                    wdata_d = bus.datawr;
                    load_d  = bus.LeerMem;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                busy_c = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (load_q) begin
                        datard_d = oor ? 32'd0 : mem[addr_q[DEPTH_LOG2-1:0]];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                // Requests still belong to the completing instruction here.
                valid_c = load_q;
                err_c   = oor;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            load_q   <= 1'b0;
            datard_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            load_q   <= load_d;
            datard_q <= datard_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    // A reset mid-access forces IDLE, so an in-flight store never reaches memory.
    always_ff @(posedge clk) begin
        if (access && !load_q && !oor) begin
            mem[addr_q[DEPTH_LOG2-1:0]] <= wdata_q;
        end
    end

    assign bus.busy   = busy_c & rst;
    assign bus.err    = err_c & rst;
    assign bus.valid  = valid_c;
    assign bus.datard = datard_q;
endmodule

// File: tb/tb_memdatos_ctrl.sv
// Bench for memdatos_ctrl: transaction-timing reference model plus directed
// scenarios with literal expectations, followed by randomized per-cycle stimulus.
module tb_memdatos_ctrl;
    localparam int DL  = 8;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    memdatos_if bus();

    memdatos_ctrl #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted request at cycle c keeps busy through c+LAT,
    // completes on the edge ending c+LAT, reports in c+LAT+1, frees at c+LAT+2.
    logic [31:0] mmem [0:(1 << DL) - 1];
    logic [31:0] m_datard;
    logic [31:0] m_addr, m_data;
    logic        m_load, m_oor;
    int          cyc, acc_start, free_at;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc       = 0;
            free_at   = 0;
            acc_start = -100;
            m_datard  = 32'd0;
            m_load    = 1'b0;
            m_oor     = 1'b0;
        end else begin
            if (cyc >= free_at) begin
                if (bus.LeerMem ^ bus.EscrMem) begin
                    acc_start = cyc;
                    free_at   = cyc + LAT + 2;
                    m_load    = bus.LeerMem;
                    m_addr    = bus.addr;
                    m_data    = bus.datawr;
                    m_oor     = (bus.addr >> DL) != 0;
                end
            end else if (cyc == acc_start + LAT) begin
                if (m_load)
                    m_datard = m_oor ? 32'd0 : mmem[m_addr[DL-1:0]];
                else if (!m_oor)
                    mmem[m_addr[DL-1:0]] = m_data;
            end
            cyc = cyc + 1;
        end
    end

    logic chk_en = 1'b0;
    logic eb, ev, ee;

    always @(negedge clk) begin
        if (rst && chk_en) begin
            if (cyc < free_at) begin
                if (cyc <= acc_start + LAT) begin
                    eb = 1'b1; ev = 1'b0; ee = 1'b0;
                end else begin
                    eb = 1'b0; ev = m_load; ee = m_oor;
                end
            end else begin
                eb = bus.LeerMem ^ bus.EscrMem;
                ev = 1'b0;
                ee = bus.LeerMem & bus.EscrMem;
            end
            chk("m_busy",   32'(bus.busy),  32'(eb));
            chk("m_valid",  32'(bus.valid), 32'(ev));
            chk("m_err",    32'(bus.err),   32'(ee));
            chk("m_datard", bus.datard,     m_datard);
        end
    end

    task automatic cycle(input logic l, input logic e, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        bus.LeerMem = l;
        bus.EscrMem = e;
        bus.addr    = a;
        bus.datawr  = d;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    int np;
    logic [31:0] ra;

    initial begin
        bus.LeerMem = 1'b0;
        bus.EscrMem = 1'b0;
        bus.addr    = 32'd0;
        bus.datawr  = 32'd0;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   32'(bus.busy),  32'd0);
        chk("rst_valid",  32'(bus.valid), 32'd0);
        chk("rst_err",    32'(bus.err),   32'd0);
        chk("rst_datard", bus.datard,     32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_busy",   32'(bus.busy),  32'd0);
        chk("rel_datard", bus.datard,     32'd0);
        chk_en = 1'b1;

        // Fill every word with a known pattern
        for (int i = 0; i < (1 << DL); i++) begin
            cycle(1'b0, 1'b1, 32'(i), 32'hA500_0000 | 32'(i));
            idle(LAT + 1);
        end

        // Store then load
        cycle(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        @(negedge clk); chk("st_busy_c0", 32'(bus.busy), 32'd1);
        for (int k = 1; k <= LAT; k++) begin
            idle(1);
            @(negedge clk);
            chk("st_busy_wait",  32'(bus.busy),  32'd1);
            chk("st_valid_wait", 32'(bus.valid), 32'd0);
        end
        idle(1);
        @(negedge clk);
        chk("st_done_busy",  32'(bus.busy),  32'd0);
        chk("st_done_valid", 32'(bus.valid), 32'd0);
        chk("st_done_err",   32'(bus.err),   32'd0);
        cycle(1'b1, 1'b0, 32'h10, 32'd0);
        @(negedge clk); chk("ld_accept_c4", 32'(bus.busy), 32'd1);
        idle(LAT + 1);
        @(negedge clk);
        chk("ld_datard", bus.datard,     32'hDEAD_BEEF);
        chk("ld_valid",  32'(bus.valid), 32'd1);
        idle(1);
        @(negedge clk); chk("ld_after_valid", 32'(bus.valid), 32'd0);

        // Illegal request
        cycle(1'b1, 1'b1, 32'h10, 32'd0);
        @(negedge clk);
        chk("ill_err",  32'(bus.err),  32'd1);
        chk("ill_busy", 32'(bus.busy), 32'd0);
        idle(1);
        @(negedge clk); chk("ill_next_busy", 32'(bus.busy), 32'd0);
        cycle(1'b1, 1'b0, 32'h10, 32'd0);
        idle(LAT + 1);
        @(negedge clk); chk("ill_mem_kept", bus.datard, 32'hDEAD_BEEF);

        // Out-of-range store and loads
        cycle(1'b0, 1'b1, 32'h100, 32'h55);
        idle(LAT + 1);
        @(negedge clk); chk("oor_st_err", 32'(bus.err), 32'd1);
        cycle(1'b1, 1'b0, 32'h0, 32'd0);
        idle(LAT + 1);
        @(negedge clk); chk("oor_ld0", bus.datard, 32'hA500_0000);
        cycle(1'b1, 1'b0, 32'h100, 32'd0);
        idle(LAT + 1);
        @(negedge clk);
        chk("oor_ld_data",  bus.datard,     32'd0);
        chk("oor_ld_err",   32'(bus.err),   32'd1);
        chk("oor_ld_valid", 32'(bus.valid), 32'd1);

        // Load request held continuously
        idle(1);
        cycle(1'b1, 1'b0, 32'h10, 32'd0);
        np = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.valid) np++;
        end
        bus.LeerMem = 1'b0;
        chk("held_pulses", 32'(np), 32'd3);
        idle(LAT + 2);

        // Reset during WAIT of a store
        cycle(1'b0, 1'b1, 32'h20, 32'h1234);
        @(negedge clk); chk("rw_busy_c0", 32'(bus.busy), 32'd1);
        idle(1);
        #1 rst = 1'b0;
        #1 chk("rw_busy_drop", 32'(bus.busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        cycle(1'b1, 1'b0, 32'h20, 32'd0);
        idle(LAT + 1);
        @(negedge clk);
        chk("rw_orig", bus.datard, 32'hA500_0020);
        chk("rw_valid", 32'(bus.valid), 32'd1);

        // Randomized per-cycle stimulus
        for (int i = 0; i < 3000; i++) begin
            ra = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, (1 << DL) - 1));
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, $urandom);
        end
        idle(LAT + 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
